// File: rtl/crc_req_arbiter.sv
// crc_req_arbiter
// Shares the single CRC request channel between NUM_REQ requesters.
// Round-robin arbitration, per-requester outstanding limits, a registered
// output slice and an in-order tag FIFO that routes completion pulses
// back to the requester that issued each request.
// Optional build macro: CRC_ARB_PRIO0_EN gives requester 0 strict priority
// (its grants do not advance the round-robin pointer).
module crc_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_W     = 64,
  parameter int TAG_DEPTH = 8,
  parameter int MAX_OUT   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*REQ_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_req_valid,
  output logic [REQ_W-1:0]           o_req_data,
  input  logic                       i_req_ready,
  input  logic                       i_done,
  output logic [NUM_REQ-1:0]         o_done,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic                       o_idle,
  output logic                       o_err
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int GW1 = GW + 1;
  localparam int AW  = $clog2(TAG_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(MAX_OUT) + 1;

  localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_OUT);
  localparam logic [GW1-1:0] NUM_REQ_W = GW1'(NUM_REQ);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(TAG_DEPTH);
  localparam logic [GW-1:0]  LAST_IDX  = GW'(NUM_REQ - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // State registers
  state_t              state_r;
  state_t              state_nxt_s;
  logic [GW-1:0]       rr_ptr_r;
  logic [CW-1:0]       cnt_r     [NUM_REQ];
  logic [CW-1:0]       cnt_nxt_s [NUM_REQ];
  logic [GW-1:0]       tag_mem_r [TAG_DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [LW-1:0]       lvl_r;

  // Combinational helpers
  logic                load_en_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;
  logic                push_s;
  logic                pop_s;
  logic [GW-1:0]       head_tag_s;
  logic [NUM_REQ-1:0]  elig_s;
  logic [GW-1:0]       win_idx_s;
  logic                win_found_s;
  logic                grant_s;
  logic [GW1-1:0]      dist_s;
  logic [GW1-1:0]      best_dist_s;
  logic [GW-1:0]       rr_ptr_nxt_s;
  logic [NUM_REQ-1:0]  inc_s;
  logic [NUM_REQ-1:0]  dec_s;
  logic [NUM_REQ-1:0]  done_nxt_s;
  logic [LW-1:0]       lvl_nxt_s;
  logic                valid_nxt_s;
  logic                any_at_max_s;

  assign load_en_s    = ~o_req_valid | i_req_ready;
  assign fifo_empty_s = (lvl_r == {LW{1'b0}});
  assign fifo_full_s  = (lvl_r == LVL_FULL);
  assign head_tag_s   = tag_mem_r[rd_ptr_r];
  assign pop_s        = ~i_reset & i_done & ~fifo_empty_s;
  assign grant_s      = ~i_reset & load_en_s & win_found_s;
  assign push_s       = grant_s;

  // Eligibility: outstanding limit and tag space (a same-cycle pop frees a slot)
  always_comb begin
    elig_s = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_req_valid[k] && (cnt_r[k] < MAX_CNT) && (!fifo_full_s || pop_s)) begin
        elig_s[k] = 1'b1;
      end else begin
        elig_s[k] = 1'b0;
      end
    end
  end

  // Winner selection: closest eligible requester at or after the RR pointer
  always_comb begin
    win_idx_s   = {GW{1'b0}};
    win_found_s = 1'b0;
    best_dist_s = NUM_REQ_W;
    dist_s      = {GW1{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (GW1'(k) >= {1'b0, rr_ptr_r}) begin
        dist_s = GW1'(k) - {1'b0, rr_ptr_r};
      end else begin
        dist_s = GW1'(k) + NUM_REQ_W - {1'b0, rr_ptr_r};
      end
      if (elig_s[k] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        win_idx_s   = GW'(k);
        win_found_s = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
`ifdef CRC_ARB_PRIO0_EN
    if (elig_s[0]) begin
      win_idx_s   = {GW{1'b0}};
      win_found_s = 1'b1;
    end else begin
      win_found_s = win_found_s;
    end
`endif
  end

  // Requester accept strobe, same cycle as the grant decision
  always_comb begin
    o_req_ready = {NUM_REQ{1'b0}};
    if (grant_s) begin
      o_req_ready[win_idx_s] = 1'b1;
    end else begin
      o_req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Next RR pointer: one past the winner (requester 0 grants keep it under priority mode)
  always_comb begin
    rr_ptr_nxt_s = rr_ptr_r;
    if (grant_s) begin
`ifdef CRC_ARB_PRIO0_EN
      if (win_idx_s == {GW{1'b0}}) begin
        rr_ptr_nxt_s = rr_ptr_r;
      end else if (win_idx_s == LAST_IDX) begin
        rr_ptr_nxt_s = {GW{1'b0}};
      end else begin
        rr_ptr_nxt_s = win_idx_s + GW'(1);
      end
`else
      if (win_idx_s == LAST_IDX) begin
        rr_ptr_nxt_s = {GW{1'b0}};
      end else begin
        rr_ptr_nxt_s = win_idx_s + GW'(1);
      end
`endif
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Outstanding counters: grant increments, completion decrements, both cancel
  always_comb begin
    inc_s      = {NUM_REQ{1'b0}};
    dec_s      = {NUM_REQ{1'b0}};
    done_nxt_s = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      inc_s[k]      = grant_s && (win_idx_s == GW'(k));
      dec_s[k]      = pop_s && (head_tag_s == GW'(k));
      done_nxt_s[k] = dec_s[k];
      case ({inc_s[k], dec_s[k]})
        2'b10:   cnt_nxt_s[k] = cnt_r[k] + CW'(1);
        2'b01:   cnt_nxt_s[k] = cnt_r[k] - CW'(1);
        default: cnt_nxt_s[k] = cnt_r[k];
      endcase
    end
  end

  // FIFO occupancy and slice valid for the next cycle (feeds registered o_idle)
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   lvl_nxt_s = lvl_r + LW'(1);
      2'b01:   lvl_nxt_s = lvl_r - LW'(1);
      default: lvl_nxt_s = lvl_r;
    endcase
    if (load_en_s) begin
      valid_nxt_s = grant_s;
    end else begin
      valid_nxt_s = o_req_valid;
    end
  end

  // Detect any requester sitting at its outstanding limit
  always_comb begin
    any_at_max_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cnt_r[k] == MAX_CNT) begin
        any_at_max_s = 1'b1;
      end else begin
        any_at_max_s = any_at_max_s;
      end
    end
  end

  // Debug status FSM next state: DRAIN while any requester is at its limit
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (any_at_max_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!any_at_max_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Status FSM register (does not affect grants)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration bookkeeping: RR pointer and outstanding counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr_r <= {GW{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_r[k] <= {CW{1'b0}};
      end
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
      end
    end
  end

  // In-order tag FIFO: push the winner, pop on each completion
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      lvl_r    <= {LW{1'b0}};
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_r[i] <= {GW{1'b0}};
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= win_idx_s;
        wr_ptr_r            <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      lvl_r <= lvl_nxt_s;
    end
  end

  // Output slice, completion pulses, idle flag and sticky error
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_req_valid <= 1'b0;
      o_req_data  <= {REQ_W{1'b0}};
      o_grant_idx <= {GW{1'b0}};
      o_done      <= {NUM_REQ{1'b0}};
      o_idle      <= 1'b1;
      o_err       <= 1'b0;
    end else begin
      o_req_valid <= valid_nxt_s;
      if (grant_s) begin
        o_req_data  <= i_req_data[win_idx_s*REQ_W +: REQ_W];
        o_grant_idx <= win_idx_s;
      end else begin
        o_req_data  <= o_req_data;
        o_grant_idx <= o_grant_idx;
      end
      o_done <= done_nxt_s;
      o_idle <= (lvl_nxt_s == {LW{1'b0}}) & ~valid_nxt_s;
      if (i_done && fifo_empty_s) begin
        o_err <= 1'b1;
      end else begin
        o_err <= o_err;
      end
    end
  end

endmodule

// File: tb/tb_crc_req_arbiter.sv
// Randomized self-checking bench for crc_req_arbiter (default parameters).
// A queue-based reference model predicts grants, slice contents,
// completion routing, idle and error flags every cycle.
module tb_crc_req_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TD = 8;
  localparam int MO = 4;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [N-1:0]      i_req_valid;
  logic [N*W-1:0]    i_req_data;
  logic [N-1:0]      o_req_ready;
  logic              o_req_valid;
  logic [W-1:0]      o_req_data;
  logic              i_req_ready;
  logic              i_done;
  logic [N-1:0]      o_done;
  logic [1:0]        o_grant_idx;
  logic              o_idle;
  logic              o_err;

  crc_req_arbiter dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_req_valid (o_req_valid),
    .o_req_data  (o_req_data),
    .i_req_ready (i_req_ready),
    .i_done      (i_done),
    .o_done      (o_done),
    .o_grant_idx (o_grant_idx),
    .o_idle      (o_idle),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           q[$];
  int           mcnt[N];
  int           mptr;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_idx;
  logic [N-1:0] m_done;
  logic         m_err;
  logic [N-1:0] last_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N*W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: drive inputs, check the accept strobe, advance the model, check the slice
  task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] dat,
                      input logic rdy, input logic dn);
    bit           load, pop, full_eff;
    bit [N-1:0]   elig;
    int           w, k, h;
    logic [N-1:0] exp_ready;
    i_reset = rst; i_req_valid = v; i_req_data = dat; i_req_ready = rdy; i_done = dn;
    #2;
    load     = !m_valid || rdy;
    pop      = dn && (q.size() > 0);
    full_eff = (q.size() == TD) && !pop;
    for (int j = 0; j < N; j++) elig[j] = v[j] && (mcnt[j] < MO) && !full_eff;
    w = -1;
`ifdef CRC_ARB_PRIO0_EN
    if (elig[0]) w = 0;
`endif
    for (int i = 0; i < N; i++) begin
      k = (mptr + i) % N;
      if (w < 0 && elig[k]) w = k;
    end
    exp_ready = '0;
    if (!rst && load && w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 64'(o_req_ready), 64'(exp_ready));
    last_ready = o_req_ready;
    if (rst) begin
      q.delete();
      for (int j = 0; j < N; j++) mcnt[j] = 0;
      mptr = 0; m_valid = 0; m_data = '0; m_idx = 0; m_done = '0; m_err = 0;
    end else begin
      m_done = '0;
      if (pop) begin
        h = q.pop_front();
        mcnt[h]--;
        m_done[h] = 1'b1;
      end
      if (dn && !pop) m_err = 1'b1;
      if (load) begin
        if (w >= 0) begin
          m_valid = 1'b1;
          m_data  = dat[w*W +: W];
          m_idx   = w;
          q.push_back(w);
          mcnt[w]++;
`ifdef CRC_ARB_PRIO0_EN
          if (w != 0) mptr = (w + 1) % N;
`else
          mptr = (w + 1) % N;
`endif
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    @(posedge i_clk);
    #1;
    chk("req_valid", 64'(o_req_valid), 64'(m_valid));
    chk("req_data", o_req_data, m_data);
    chk("grant_idx", 64'(o_grant_idx), 64'(m_idx));
    chk("done", 64'(o_done), 64'(m_done));
    chk("idle", 64'(o_idle), 64'((q.size() == 0) && !m_valid));
    chk("err", 64'(o_err), 64'(m_err));
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b0);
  endtask

  logic [N*W-1:0] d;
  int             g;
  logic           dn;

  initial begin
    m_valid = 0; m_data = '0; m_idx = 0; m_done = '0; m_err = 0; mptr = 0;
    for (int j = 0; j < N; j++) mcnt[j] = 0;

    // Reset state
    do_reset();
    chk("rst_idle", 64'(o_idle), 64'd1);

    // Single requester with the A5 payload
    d = rnd_data();
    d[2*W +: W] = 64'hA5;
    step(1'b0, 4'b0100, d, 1'b1, 1'b0);
    chk("a5_ready", 64'(last_ready), 64'h4);
    chk("a5_data", o_req_data, 64'hA5);
    chk("a5_idx", 64'(o_grant_idx), 64'd2);
    step(1'b0, 4'b0000, d, 1'b1, 1'b0);
    step(1'b0, 4'b0000, d, 1'b1, 1'b1);
    chk("a5_done", 64'(o_done), 64'h4);
    chk("a5_idle", 64'(o_idle), 64'd1);

    // Fairness: all requesters valid, downstream always ready
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 4'hF, rnd_data(), 1'b1, i > 0);

    // Backpressure with two requesters, then release
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0011, rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, rnd_data(), 1'b1, 1'b0);

    // Outstanding limit on requester 1
    do_reset();
    g = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'b0010, rnd_data(), 1'b1, 1'b0);
      g += int'(last_ready[1]);
    end
    chk("limit_grants", 64'(g), 64'd4);
    step(1'b0, 4'b0010, rnd_data(), 1'b1, 1'b1);
    chk("limit_done", 64'(o_done), 64'h2);
    step(1'b0, 4'b0010, rnd_data(), 1'b1, 1'b0);
    chk("limit_5th", 64'(last_ready), 64'h2);

    // Fill the tag FIFO, then complete while requesting
    do_reset();
    g = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 4'hF, rnd_data(), 1'b1, 1'b0);
      g += $countones(last_ready);
    end
    chk("full_grants", 64'(g), 64'd8);
    for (int i = 0; i < 3; i++) step(1'b0, 4'hF, rnd_data(), 1'b1, 1'b1);
    chk("full_idle", 64'(o_idle), 64'd0);

    // Completion with nothing in flight is sticky
    do_reset();
    step(1'b0, 4'b0000, rnd_data(), 1'b1, 1'b1);
    chk("err_set", 64'(o_err), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, rnd_data(), 1'b1, 1'b0);
    chk("err_sticky", 64'(o_err), 64'd1);

    // Reset in the middle of traffic drops in-flight state
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'hF, rnd_data(), 1'b1, 1'b0);
    step(1'b1, 4'hF, rnd_data(), 1'b1, 1'b1);
    chk("mid_rst_valid", 64'(o_req_valid), 64'd0);
    step(1'b0, 4'b0000, rnd_data(), 1'b1, 1'b1);
    chk("mid_rst_err", 64'(o_err), 64'd1);

    // Randomized traffic, segments separated by reset
    for (int s = 0; s < 8; s++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        if (q.size() > 0) dn = ($urandom_range(0, 2) == 0);
        else dn = (s >= 6) && ($urandom_range(0, 19) == 0);
        step(1'b0, N'($urandom), rnd_data(), ($urandom_range(0, 3) != 0), dn);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_req_arbiter.md
Name: crc_req_arbiter

Overview:
- Shares the single CRC request channel between NUM_REQ independent requesters (DMA, register, test ports).
- Round-robin arbitration with per-requester outstanding limits.
- Registered output slice feeding the CRC request-processing stage.
- In-order completion tag FIFO that routes each completion pulse back to the requester that issued the request.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_W, 64, request payload width (matches CRC request struct width).
- TAG_DEPTH, 8, tag FIFO depth (power of two); bounds total in-flight requests.
- MAX_OUT, 4, per-requester outstanding limit (power of two, ≤ TAG_DEPTH).

Ports:
- i_clk  in  1  clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_data  in  NUM_REQ*REQ_W  per-requester payload; requester k occupies bits [k*REQ_W +: REQ_W].
- o_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- o_req_valid  out  1  downstream request valid.
- o_req_data  out  REQ_W  downstream payload.
- i_req_ready  in  1  downstream accept.
- i_done  in  1  one-cycle completion pulse from downstream; completions return in issue order.
- o_done  out  NUM_REQ  per-requester completion pulse.
- o_grant_idx  out  $clog2(NUM_REQ)  index of the requester held in the output slice.
- o_idle  out  1  no requests in flight and output slice empty.
- o_err  out  1  sticky: completion received with tag FIFO empty.

Behaviour:
- Reset (synchronous, active-high, i_reset sampled on i_clk):
  - o_req_valid=0, o_req_data=0, o_req_ready=0, o_done=0, o_grant_idx=0, o_err=0, o_idle=1.
  - RR pointer=0, all outstanding counters=0, tag FIFO empty.
  - Reset asserted mid-operation drops all in-flight state; any later i_done is then flagged through o_err.
- Slice free: load_en = ~o_req_valid | i_req_ready.
- Eligibility, per requester k: elig[k] = i_req_valid[k] & (cnt[k] < MAX_OUT) & tag FIFO not full.
  - When the FIFO is full but popping in the same cycle, it counts as not full.
- Arbitration:
  - Combinational round-robin over elig, starting at ptr.
  - If load_en and any elig: winner g, o_req_ready[g]=1 in the same cycle (combinational).
  - At the clock edge: o_req_data <= data[g], o_req_valid <= 1, o_grant_idx <= g, push g into the tag FIFO, cnt[g]++, ptr <= (g+1) mod NUM_REQ.
  - If load_en and no elig: o_req_valid <= 0.
  - While o_req_valid & ~i_req_ready: o_req_data and o_grant_idx stay stable, no grant.
- Throughput and latency:
  - Back-to-back grants, one per cycle, while the downstream is ready.
  - One cycle from requester handshake to o_req_valid.
- Completion:
  - i_done with FIFO non-empty: pop head tag t; o_done[t] pulses one cycle later (registered); cnt[t]-- in the pop cycle.
  - i_done with FIFO empty: ignored, o_err <= 1 (sticky until reset).
- Simultaneous grant and completion on the same requester: cnt unchanged. FIFO push and pop in the same cycle are both legal, including when full.
- Counters: width $clog2(MAX_OUT)+1, no wrap (saturation prevented by eligibility).
- o_idle = FIFO empty & ~o_req_valid.
- State machine: two states.
  - RUN: normal arbitration.
  - DRAIN: entered when any cnt reaches MAX_OUT. Arbitration continues for the other requesters. Exits to RUN when all cnt < MAX_OUT.
  - A 1-bit status register reflects the state for debug visibility; it does not change grant behaviour.

Optional Feature:
- Macro: CRC_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. If elig[0], it wins regardless of ptr, and ptr is not updated on a requester-0 grant. The remaining requesters use round-robin.
- Undefined: pure round-robin for all requesters, including requester 0.

Test Plan:
- Single requester: reset, i_req_valid[2]=1, data=64'hA5, i_req_ready=1 -> o_req_ready[2] in cycle 0; o_req_valid=1, o_req_data=64'hA5, o_grant_idx=2 in cycle 1; i_done -> o_done[2] one cycle later; o_idle returns to 1.
- Fairness: all 4 requesters continuously valid, i_req_ready=1 -> grant order 0,1,2,3,0,1,... one per cycle. With CRC_ARB_PRIO0_EN defined -> requester 0 every cycle until cnt[0]=4, then 1,2,3.
- Backpressure: i_req_ready=0 for 5 cycles with 2 requesters valid -> o_req_data/o_grant_idx stable, o_req_ready=0 after the first load. Release -> next grant goes to the other requester.
- Limits: requester 1 alone, no i_done -> exactly 4 grants, then o_req_ready[1]=0. One i_done -> o_done[1] pulses, a 5th grant follows. With TAG_DEPTH=8, 8 grants across requesters and no i_done -> all blocked.
- Simultaneous: FIFO full, i_done in the same cycle as an eligible request -> grant occurs, FIFO stays full, cnt of a same-requester pair unchanged.
- Errors/reset: i_done with FIFO empty -> o_err=1 and it stays set. i_reset mid-stream with 3 in flight -> all outputs return to reset values the next cycle; a subsequent i_done sets o_err.
